// File: rtl/xor_bind_checker.sv
// ---------------------------------------------------------------------------
// xor_bind_checker
//
// Bindable self-checking monitor for XOR datapaths. It watches a host's
// operands a/b and its result c, predicts a ^ b, delays the prediction by
// the host latency and compares it with c. Results are kept in saturating
// counters, a sticky error flag and a capture of the first failing compare.
//
// Parameters
//   WIDTH    data width of a, b, c (>= 1)
//   LATENCY  host cycles from operands to result (0..15)
//   CNT_W    width of both counters (>= 2)
//
// Ports
//   clk           sole clock, rising edge
//   rst           asynchronous active-high reset, clears all state
//   a, b          host operands
//   c             host result under check
//   in_valid      qualifies a/b for checking this cycle
//   clear         synchronous clear of counters, flag and captures
//   err           sticky mismatch flag
//   check_cnt     comparisons performed (saturating)
//   mismatch_cnt  failed comparisons (saturating)
//   first_exp     expected value at the first mismatch
//   first_got     observed c at the first mismatch
// ---------------------------------------------------------------------------
module xor_bind_checker #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             in_valid,
    input  logic             clear,
    output logic             err,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_got
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Prediction chain: index 0 is the fresh prediction from this cycle's
    // operands, index k is the output of pipeline stage k-1. The compare
    // point is always index LATENCY, so LATENCY = 0 naturally compares the
    // combinational prediction against the same-cycle c.
    logic [LATENCY:0]            chain_valid;
    logic [LATENCY:0][WIDTH-1:0] chain_exp;

    assign chain_valid[0] = in_valid;
    assign chain_exp[0]   = a ^ b;

    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
            logic             valid_reg;
            logic [WIDTH-1:0] exp_reg;

            // Stages shift every edge; invalid entries travel through as
            // bubbles. clear deliberately leaves the chain alone so that
            // in-flight predictions are still checked afterwards.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    exp_reg   <= '0;
                end else begin
                    valid_reg <= chain_valid[gi];
                    exp_reg   <= chain_exp[gi];
                end
            end

            assign chain_valid[gi+1] = valid_reg;
            assign chain_exp[gi+1]   = exp_reg;
        end
    endgenerate

    // Compare point
    logic             cmp_valid;
    logic [WIDTH-1:0] cmp_exp;
    logic             cmp_fail;

    assign cmp_valid = chain_valid[LATENCY];
    assign cmp_exp   = chain_exp[LATENCY];
    // Plain full-width inequality; unknown bits on c are not treated
    // specially.
    assign cmp_fail  = cmp_valid && (c != cmp_exp);

    // Result state
    logic             err_reg;
    logic             err_next;
    logic [CNT_W-1:0] check_cnt_reg;
    logic [CNT_W-1:0] check_cnt_next;
    logic [CNT_W-1:0] mismatch_cnt_reg;
    logic [CNT_W-1:0] mismatch_cnt_next;
    logic [WIDTH-1:0] first_exp_reg;
    logic [WIDTH-1:0] first_exp_next;
    logic [WIDTH-1:0] first_got_reg;
    logic [WIDTH-1:0] first_got_next;

    always_comb begin
        err_next          = err_reg;
        check_cnt_next    = check_cnt_reg;
        mismatch_cnt_next = mismatch_cnt_reg;
        first_exp_next    = first_exp_reg;
        first_got_next    = first_got_reg;

        if (clear) begin
            // clear wins over a simultaneous compare event; that event is
            // simply dropped.
            err_next          = 1'b0;
            check_cnt_next    = '0;
            mismatch_cnt_next = '0;
            first_exp_next    = '0;
            first_got_next    = '0;
        end else if (cmp_valid) begin
            if (check_cnt_reg != CNT_MAX) begin
                check_cnt_next = check_cnt_reg + 1'b1;
            end
            if (cmp_fail) begin
                if (mismatch_cnt_reg != CNT_MAX) begin
                    mismatch_cnt_next = mismatch_cnt_reg + 1'b1;
                end
                // Only the first failure since reset/clear is captured;
                // err doubles as the "capture taken" marker.
                if (!err_reg) begin
                    err_next       = 1'b1;
                    first_exp_next = cmp_exp;
                    first_got_next = c;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg          <= 1'b0;
            check_cnt_reg    <= '0;
            mismatch_cnt_reg <= '0;
            first_exp_reg    <= '0;
            first_got_reg    <= '0;
        end else begin
            err_reg          <= err_next;
            check_cnt_reg    <= check_cnt_next;
            mismatch_cnt_reg <= mismatch_cnt_next;
            first_exp_reg    <= first_exp_next;
            first_got_reg    <= first_got_next;
        end
    end

    assign err          = err_reg;
    assign check_cnt    = check_cnt_reg;
    assign mismatch_cnt = mismatch_cnt_reg;
    assign first_exp    = first_exp_reg;
    assign first_got    = first_got_reg;

endmodule

// File: tb/tb_xor_bind_checker.sv
// ---------------------------------------------------------------------------
// tb_xor_bind_checker
//
// Three checker instances share operands and control:
//   index 0: LATENCY=2, CNT_W=8
//   index 1: LATENCY=0, CNT_W=2
//   index 2: LATENCY=3, CNT_W=8
// Each has its own c. Stimulus pushes every issued prediction into a
// per-instance queue; a monitor pops the prediction that is due, updates a
// reference model of the outputs and compares every cycle.
// ---------------------------------------------------------------------------
module tb_xor_bind_checker;

    localparam int N = 3;

    typedef struct packed {
        logic       v;
        logic [7:0] e;
    } pred_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [7:0] c_v [N];

    logic       err_v  [N];
    logic [7:0] fexp_v [N];
    logic [7:0] fgot_v [N];
    logic [7:0] chk2, mis2, chk3, mis3;
    logic [1:0] chk0, mis0;

    always #5 clk = ~clk;

    xor_bind_checker #(.WIDTH(8), .LATENCY(2), .CNT_W(8)) u_lat2 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c_v[0]),
        .in_valid(in_valid), .clear(clear), .err(err_v[0]),
        .check_cnt(chk2), .mismatch_cnt(mis2),
        .first_exp(fexp_v[0]), .first_got(fgot_v[0])
    );

    xor_bind_checker #(.WIDTH(8), .LATENCY(0), .CNT_W(2)) u_lat0 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c_v[1]),
        .in_valid(in_valid), .clear(clear), .err(err_v[1]),
        .check_cnt(chk0), .mismatch_cnt(mis0),
        .first_exp(fexp_v[1]), .first_got(fgot_v[1])
    );

    xor_bind_checker #(.WIDTH(8), .LATENCY(3), .CNT_W(8)) u_lat3 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c_v[2]),
        .in_valid(in_valid), .clear(clear), .err(err_v[2]),
        .check_cnt(chk3), .mismatch_cnt(mis3),
        .first_exp(fexp_v[2]), .first_got(fgot_v[2])
    );

    // Reference model
    int         lat  [N] = '{2, 0, 3};
    int         cmax [N] = '{255, 3, 255};
    pred_t      pq   [N][$];
    int         m_chk  [N];
    int         m_mis  [N];
    logic       m_err  [N];
    logic [7:0] m_fexp [N];
    logic [7:0] m_fgot [N];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic zero_model(input int i);
        m_chk[i]  = 0;
        m_mis[i]  = 0;
        m_err[i]  = 1'b0;
        m_fexp[i] = 8'h00;
        m_fgot[i] = 8'h00;
    endtask

    function automatic logic [39:0] dut_snap(input int i);
        case (i)
            0:       return {7'b0, err_v[0], chk2, mis2, fexp_v[0], fgot_v[0]};
            1:       return {7'b0, err_v[1], 6'b0, chk0, 6'b0, mis0, fexp_v[1], fgot_v[1]};
            default: return {7'b0, err_v[2], chk3, mis3, fexp_v[2], fgot_v[2]};
        endcase
    endfunction

    function automatic logic [39:0] model_snap(input int i);
        return {7'b0, m_err[i], 8'(m_chk[i]), 8'(m_mis[i]), m_fexp[i], m_fgot[i]};
    endfunction

    function automatic logic [7:0] r8();
        return 8'($urandom);
    endfunction

    // Monitor: model update at the active edge, comparison half a cycle later.
    initial begin
        pred_t p;
        logic  ev;
        for (int i = 0; i < N; i++) zero_model(i);
        forever begin
            @(posedge clk);
            for (int i = 0; i < N; i++) begin
                ev = 1'b0;
                p  = '0;
                if (rst) begin
                    zero_model(i);
                end else begin
                    if (pq[i].size() > lat[i]) begin
                        p  = pq[i].pop_front();
                        ev = p.v;
                    end
                    if (clear) begin
                        zero_model(i);
                    end else if (ev) begin
                        if (m_chk[i] < cmax[i]) m_chk[i]++;
                        if (c_v[i] != p.e) begin
                            if (m_mis[i] < cmax[i]) m_mis[i]++;
                            if (!m_err[i]) begin
                                m_err[i]  = 1'b1;
                                m_fexp[i] = p.e;
                                m_fgot[i] = c_v[i];
                            end
                        end
                    end
                end
            end
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                check($sformatf("state_u%0d", i), dut_snap(i), model_snap(i));
            end
        end
    end

    // One cycle of stimulus, called at a falling edge. fN is XORed into the
    // correct result of instance N when a valid prediction is due.
    task automatic cycle(input logic v, input logic [7:0] av, input logic [7:0] bv,
                         input logic clr, input logic [7:0] f0, input logic [7:0] f1,
                         input logic [7:0] f2);
        pred_t      p;
        logic [7:0] fm [N];
        fm[0] = f0;
        fm[1] = f1;
        fm[2] = f2;
        in_valid = v;
        a        = av;
        b        = bv;
        clear    = clr;
        p.v      = v;
        p.e      = av ^ bv;
        for (int i = 0; i < N; i++) begin
            pq[i].push_back(p);
            if (pq[i].size() > lat[i] && pq[i][0].v)
                c_v[i] = pq[i][0].e ^ fm[i];
            else
                c_v[i] = r8();
        end
        $display("[TB] t=%0t v=%0d a=%h b=%h clr=%0d c=%h/%h/%h", $time, v, av, bv, clr,
                 c_v[0], c_v[1], c_v[2]);
        @(negedge clk);
    endtask

    task automatic mid_reset();
        in_valid = 1'b0;
        clear    = 1'b0;
        #2 rst = 1'b1;
        for (int i = 0; i < N; i++) pq[i].delete();
        #1;
        for (int i = 0; i < N; i++) check($sformatf("async_rst_u%0d", i), dut_snap(i), 40'h0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < N; i++) c_v[i] = 8'h00;

        // Power-up reset
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) check($sformatf("reset_u%0d", i), dut_snap(i), 40'h0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // Clean stream: first increment after the edge ending cycle 2
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 8'h0F ^ 8'(k), 8'hF0 + 8'(k), 1'b0, 8'h00, 8'h00, 8'h00);
            check("clean_cnt_timing", chk2, (k >= 2) ? 40'(k - 1) : 40'd0);
        end
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        check("clean_check_cnt", chk2, 40'd10);
        check("clean_mismatch_cnt", mis2, 40'd0);
        check("clean_err", err_v[0], 40'd0);

        // Single fault (cycle numbering starts at the clear cycle)
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00);
        repeat (4) cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        cycle(1'b1, 8'hAA, 8'h55, 1'b0, 8'h00, 8'h00, 8'h00);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        check("fault_err_before", err_v[0], 40'd0);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h01, 8'h00, 8'h00);
        check("fault_err", err_v[0], 40'd1);
        check("fault_mismatch_cnt", mis2, 40'd1);
        check("fault_first_exp", fexp_v[0], 40'hFF);
        check("fault_first_got", fgot_v[0], 40'hFE);
        cycle(1'b1, 8'h33, 8'h33, 1'b0, 8'h00, 8'h00, 8'h00);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h01, 8'h00, 8'h00);
        check("fault2_mismatch_cnt", mis2, 40'd2);
        check("fault2_first_exp", fexp_v[0], 40'hFF);
        check("fault2_first_got", fgot_v[0], 40'hFE);

        // Saturation on the CNT_W=2, LATENCY=0 instance (also same-cycle compare)
        repeat (4) cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, r8(), r8(), 1'b0, 8'h00, 8'h80, 8'h00);
            if (k == 0) begin
                check("lat0_err_same_cycle", err_v[1], 40'd1);
                check("lat0_check_cnt_1", chk0, 40'd1);
            end
        end
        check("sat_check_cnt", chk0, 40'd3);
        check("sat_mismatch_cnt", mis0, 40'd3);
        check("sat_err", err_v[1], 40'd1);

        // Clear coinciding with a mismatching compare
        repeat (4) cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        cycle(1'b1, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 8'h00);
        cycle(1'b1, 8'h56, 8'h78, 1'b0, 8'h00, 8'h00, 8'h00);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 8'h00, 8'h00);
        check("clear_wins", dut_snap(0), 40'h0);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        check("clear_inflight_cnt", chk2, 40'd1);
        check("clear_inflight_err", err_v[0], 40'd0);

        // Reset with three predictions in flight
        repeat (3) cycle(1'b1, r8(), r8(), 1'b0, 8'h00, 8'h00, 8'h00);
        mid_reset();
        repeat (3) begin
            cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
            check("post_rst_no_compare", chk3, 40'd0);
        end
        cycle(1'b1, 8'h5A, 8'h5A, 1'b0, 8'h00, 8'h01, 8'h00);
        check("lat0_post_rst_err", err_v[1], 40'd1);
        check("lat0_post_rst_got", fgot_v[1], 40'h01);

        // Randomised traffic with occasional faults, clears and a reset
        for (int k = 0; k < 600; k++) begin
            if (k == 300) mid_reset();
            cycle(($urandom % 10) < 7, r8(), r8(), ($urandom % 40) == 0,
                  (($urandom % 8) == 0) ? r8() : 8'h00,
                  (($urandom % 8) == 0) ? r8() : 8'h00,
                  (($urandom % 8) == 0) ? r8() : 8'h00);
        end
        repeat (5) cycle(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);

        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
